fma16_unpack: RTL and testbench

Sequential half-precision operand unpacker for the fma16 datapath. It accepts one IEEE-754 binary16 word per valid/ready handshake and returns its decoded fields: sign, unbiased signed exponent, and an 11-bit significand with the leading one made explicit. It also returns class flags for the value. It is the decode counterpart of the rounding/packing stage: the rounding stage packs sign, exponent and fraction into 16 bits, and this block unpacks them, normalizing subnormals iteratively at one bit per cycle.

---
 rtl/fma16_pkg.sv | 33 +++
 rtl/fma16_unpack_if.sv | 31 +++
 rtl/fp16_classify.sv | 32 +++
 rtl/fma16_unpack.sv | 121 ++++++++++++
 tb/tb_fma16_unpack.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/fma16_pkg.sv
// Shared binary16 definitions for the fma16 datapath: field widths, exponent
// constants, unpacker state encoding and the operand class record.
package fma16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int SIG_W  = 11;
  localparam int UEXP_W = 7;

  localparam int FP16_BIAS        = 15;
  localparam int FP16_EMIN        = -14;
  localparam int FP16_EXP_SPECIAL = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } unpack_state_t;

  typedef struct packed {
    logic zero;
    logic subnormal;
    logic inf;
    logic nan;
    logic snan;
  } fp16_class_t;

  // Biased 5-bit exponent to unbiased two's complement in the wider field.
  function automatic logic [UEXP_W-1:0] fp16_unbias(input logic [EXP_W-1:0] e);
    return UEXP_W'({2'b00, e}) - UEXP_W'(FP16_BIAS);
  endfunction

endpackage

// File: rtl/fma16_unpack_if.sv
// Handshake bundle between the operand source, the unpacker and its consumer.
interface fma16_unpack_if;
  import fma16_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [15:0]           in_x;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sign;
  logic [UEXP_W-1:0]     out_exp;
  logic [SIG_W-1:0]      out_sig;
  logic                  out_zero;
  logic                  out_subnormal;
  logic                  out_inf;
  logic                  out_nan;
  logic                  out_snan;

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_sig,
           out_zero, out_subnormal, out_inf, out_nan, out_snan
  );

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_sig,
           out_zero, out_subnormal, out_inf, out_nan, out_snan
  );

endinterface

// File: rtl/fp16_classify.sv
// Combinational binary16 classifier: class flags plus the implicit leading bit.
module fp16_classify
  import fma16_pkg::*;
(
  input  logic [15:0]  x,
  output fp16_class_t  cls,
  output logic         hidden
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;
  logic              exp_zero;
  logic              exp_max;
  logic              frac_nz;

  assign exp_f  = x[14:10];
  assign frac_f = x[9:0];

  always_comb begin
    exp_zero      = (exp_f == '0);
    exp_max       = &exp_f;
    frac_nz       = |frac_f;
    cls.zero      = exp_zero & ~frac_nz;
    cls.subnormal = exp_zero & frac_nz;
    cls.inf       = exp_max & ~frac_nz;
    cls.nan       = exp_max & frac_nz;
    // Quiet bit clear marks a signaling NaN; still reported as nan too.
    cls.snan      = exp_max & frac_nz & ~frac_f[FRAC_W-1];
    hidden        = ~exp_zero;
  end

endmodule

// File: rtl/fma16_unpack.sv
// Sequential binary16 unpacker: decodes sign/exponent/significand and class,
// normalizing subnormals one bit per cycle.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// NORM  | shifting a subnormal significand until bit 10 is set
// DONE  | result held on the outputs until out_ready
module fma16_unpack
  import fma16_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  fma16_unpack_if.slave        bus
);

  unpack_state_t     state_q;
  unpack_state_t     state_d;

  logic              sign_q;
  logic [UEXP_W-1:0] exp_q;
  logic [SIG_W-1:0]  sig_q;
  fp16_class_t       cls_q;

  fp16_class_t       in_cls;
  logic              in_hidden;
  logic              in_ready_c;
  logic              out_valid_c;
  logic              accept;
  logic [UEXP_W-1:0] load_exp;
  logic [SIG_W-1:0]  load_sig;

  fp16_classify u_classify (
    .x      (bus.in_x),
    .cls    (in_cls),
    .hidden (in_hidden)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_d = in_cls.subnormal ? NORM : DONE;
        end
      end
      NORM: begin
        // Bit 9 set now means bit 10 is set after this edge's shift.
        if (sig_q[SIG_W-2]) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          in_ready_c = 1'b1;
          if (bus.in_valid) begin
            state_d = in_cls.subnormal ? NORM : DONE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = bus.in_valid & in_ready_c;

  always_comb begin
    load_sig = {in_hidden, bus.in_x[9:0]};
    load_exp = fp16_unbias(bus.in_x[14:10]);
    if (in_cls.zero) begin
      load_exp = '0;
    end else if (in_cls.subnormal) begin
      load_exp = UEXP_W'(FP16_EMIN);
    end else if (in_cls.inf || in_cls.nan) begin
      load_exp = UEXP_W'(FP16_EXP_SPECIAL);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      sig_q  <= '0;
      cls_q  <= '0;
    end else if (accept) begin
      sign_q <= bus.in_x[15];
      exp_q  <= load_exp;
      sig_q  <= load_sig;
      cls_q  <= in_cls;
    end else if (state_q == NORM) begin
      // Worst case 0x0001 takes ten steps from -14 down to -24; no wrap.
      sig_q <= {sig_q[SIG_W-2:0], 1'b0};
      exp_q <= exp_q - UEXP_W'(1);
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = out_valid_c;
  assign bus.out_sign      = sign_q;
  assign bus.out_exp       = exp_q;
  assign bus.out_sig       = sig_q;
  assign bus.out_zero      = cls_q.zero;
  assign bus.out_subnormal = cls_q.subnormal;
  assign bus.out_inf       = cls_q.inf;
  assign bus.out_nan       = cls_q.nan;
  assign bus.out_snan      = cls_q.snan;

endmodule

// File: tb/tb_fma16_unpack.sv
// Directed-vector bench for fma16_unpack: decode table plus back-to-back,
// back-pressure and mid-normalization reset sequences.
module tb_fma16_unpack;

  typedef struct {
    logic [15:0] x;
    logic        sign;
    logic [6:0]  exp;
    logic [10:0] sig;
    logic [4:0]  flags;   // {zero, subnormal, inf, nan, snan}
    int          lat;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  vec_t vt[12];

  fma16_unpack_if bus();

  fma16_unpack dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] flags_now();
    return {bus.out_zero, bus.out_subnormal, bus.out_inf, bus.out_nan, bus.out_snan};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    @(negedge clk);
    chk("idle_in_ready", int'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.in_x      = v.x;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_x     = 16'hDEAD;
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("lat_%04h", v.x), cyc, v.lat);
    chk($sformatf("sign_%04h", v.x), int'(bus.out_sign), int'(v.sign));
    chk($sformatf("exp_%04h", v.x), int'(bus.out_exp), int'(v.exp));
    chk($sformatf("sig_%04h", v.x), int'(bus.out_sig), int'(v.sig));
    chk($sformatf("flags_%04h", v.x), int'(flags_now()), int'(v.flags));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk($sformatf("consumed_%04h", v.x), int'(bus.out_valid), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vt[0]  = '{16'h3C00, 1'b0, 7'h00, 11'h400, 5'b00000, 1};
    vt[1]  = '{16'h0001, 1'b0, 7'h68, 11'h400, 5'b01000, 11};
    vt[2]  = '{16'h0200, 1'b0, 7'h71, 11'h400, 5'b01000, 2};
    vt[3]  = '{16'h7C01, 1'b0, 7'h10, 11'h401, 5'b00011, 1};
    vt[4]  = '{16'hFC00, 1'b1, 7'h10, 11'h400, 5'b00100, 1};
    vt[5]  = '{16'h8000, 1'b1, 7'h00, 11'h000, 5'b10000, 1};
    vt[6]  = '{16'h7E00, 1'b0, 7'h10, 11'h600, 5'b00010, 1};
    vt[7]  = '{16'h03FF, 1'b0, 7'h71, 11'h7FE, 5'b01000, 2};
    vt[8]  = '{16'h7BFF, 1'b0, 7'h0F, 11'h7FF, 5'b00000, 1};
    vt[9]  = '{16'h0400, 1'b0, 7'h72, 11'h400, 5'b00000, 1};
    vt[10] = '{16'h8001, 1'b1, 7'h68, 11'h400, 5'b01000, 11};
    vt[11] = '{16'h0010, 1'b0, 7'h6C, 11'h400, 5'b01000, 7};

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = 16'h0000;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_exp", int'(bus.out_exp), 0);
    chk("rst_sig", int'(bus.out_sig), 0);
    chk("rst_flags_sign", int'({flags_now(), bus.out_sign}), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec(vt[i]);
    end

    // Back-to-back 0x4000 then 0xC500 with out_ready held high.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_x      = 16'h4000;
    chk("b2b_in_ready0", int'(bus.in_ready), 1);
    @(negedge clk);
    chk("b2b_valid1", int'(bus.out_valid), 1);
    chk("b2b_exp1", int'(bus.out_exp), 7'h01);
    chk("b2b_sig1", int'(bus.out_sig), 11'h400);
    chk("b2b_in_ready1", int'(bus.in_ready), 1);
    bus.in_x = 16'hC500;
    @(negedge clk);
    chk("b2b_valid2", int'(bus.out_valid), 1);
    chk("b2b_sign2", int'(bus.out_sign), 1);
    chk("b2b_exp2", int'(bus.out_exp), 7'h02);
    chk("b2b_sig2", int'(bus.out_sig), 11'h500);
    chk("b2b_in_ready2", int'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_idle", int'(bus.out_valid), 0);
    bus.out_ready = 1'b0;

    // Back-pressure: hold 0xC000 (exp 1, sig 0x400, sign 1) for 5 cycles.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = 16'hC000;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      bus.in_x = 16'h7C00 ^ 16'(k);
      chk($sformatf("bp_valid_%0d", k), int'(bus.out_valid), 1);
      chk($sformatf("bp_in_ready_%0d", k), int'(bus.in_ready), 0);
      chk($sformatf("bp_word_%0d", k),
          int'({bus.out_sign, bus.out_exp, bus.out_sig, flags_now()}),
          int'({1'b1, 7'h01, 11'h400, 5'b00000}));
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_release_valid", int'(bus.out_valid), 0);
    chk("bp_release_in_ready", int'(bus.in_ready), 1);

    // Reset during NORM of 0x0001, then a clean 0x3C00.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = 16'h0001;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("norm_no_valid", int'(bus.out_valid), 0);
    chk("norm_in_ready", int'(bus.in_ready), 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", int'(bus.out_valid), 0);
    chk("arst_exp", int'(bus.out_exp), 0);
    chk("arst_sig", int'(bus.out_sig), 0);
    chk("arst_flags_sign", int'({flags_now(), bus.out_sign}), 0);
    chk("arst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    run_vec(vt[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
